bcd_gate_ctrl: RTL and testbench

Measurement-window sequencer for the four-digit ripple BCD counter used in the frequency-meter datapath. It clears the counter, opens a gate (counter enable) for a fixed number of system clocks, waits for the ripple chain to settle, then latches the 16-bit BCD result and an overflow flag for the display stage. With `run` held high it repeats continuously; deasserting `run` stops it cleanly.

---
 rtl/fm_pkg.sv | 25 ++
 rtl/cycle_timer.sv | 26 ++
 rtl/bcd_gate_ctrl.sv | 128 ++++++++++++
 tb/tb_bcd_gate_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fm_pkg.sv
// rtl/fm_pkg.sv - shared types and defaults for the frequency-meter gate sequencer
package fm_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    GATE,
    SETTLE,
    HOLD
  } gate_state_t;

  localparam int unsigned DEF_GATE_CYCLES   = 50_000_000;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;
  localparam int unsigned DEF_HOLD_CYCLES   = 50_000_000;

  typedef logic [15:0] bcd4_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cycle_timer.sv
// rtl/cycle_timer.sv - loadable down-counter; done while the count is zero
module cycle_timer #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign done = (r_count == '0);

endmodule

// File: rtl/bcd_gate_ctrl.sv
// rtl/bcd_gate_ctrl.sv - clear/gate/settle/hold sequencer latching the BCD counter result
module bcd_gate_ctrl
  import fm_pkg::*;
#(
  parameter int unsigned GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [15:0] count_in,
  input  logic        ovf_in,
  output logic        cnt_clear,
  output logic        cnt_enable,
  output logic [15:0] result,
  output logic        result_ovf,
  output logic        result_valid,
  output logic        busy
);

  localparam int unsigned TW = $clog2(max3(GATE_CYCLES, SETTLE_CYCLES, HOLD_CYCLES)) + 1;

  gate_state_t r_state;
  gate_state_t w_next;
  logic        w_load;
  logic [TW-1:0] w_load_val;
  logic        w_done;
  logic        w_latch;

  logic        r_cnt_clear;
  logic        r_cnt_enable;
  logic        r_busy;
  bcd4_t       r_result;
  logic        r_result_ovf;
  logic        r_result_valid;
  logic        r_sticky_ovf;

  cycle_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_load),
    .load_val (w_load_val),
    .done     (w_done)
  );

  // Timer is loaded with N-1 on entry so that done marks the last cycle of the state.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_latch    = 1'b0;
    case (r_state)
      IDLE: begin
        if (run) w_next = CLEAR;
      end
      CLEAR: begin
        if (!run) begin
          w_next = IDLE;
        end else begin
          w_next     = GATE;
          w_load     = 1'b1;
          w_load_val = TW'(GATE_CYCLES - 1);
        end
      end
      GATE: begin
        if (!run) begin
          w_next = IDLE;
        end else if (w_done) begin
          w_next     = SETTLE;
          w_load     = 1'b1;
          w_load_val = TW'(SETTLE_CYCLES - 1);
        end
      end
      SETTLE: begin
        if (!run) begin
          w_next = IDLE;
        end else if (w_done) begin
          w_next     = HOLD;
          w_load     = 1'b1;
          w_load_val = TW'(HOLD_CYCLES - 1);
          w_latch    = 1'b1;
        end
      end
      HOLD: begin
        if (w_done) w_next = run ? CLEAR : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Port-facing bits are registered from the next state so cnt_clear stays glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt_clear    <= 1'b0;
      r_cnt_enable   <= 1'b0;
      r_busy         <= 1'b0;
      r_result       <= '0;
      r_result_ovf   <= 1'b0;
      r_result_valid <= 1'b0;
      r_sticky_ovf   <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_cnt_clear    <= (w_next == CLEAR);
      r_cnt_enable   <= (w_next == GATE);
      r_busy         <= (w_next != IDLE);
      r_result_valid <= w_latch;
      if (w_latch) begin
        r_result     <= count_in;
        r_result_ovf <= r_sticky_ovf | ovf_in;
      end
      if (r_state == CLEAR) begin
        r_sticky_ovf <= 1'b0;
      end else if (r_state == GATE || r_state == SETTLE) begin
        r_sticky_ovf <= r_sticky_ovf | ovf_in;
      end
    end
  end

  assign cnt_clear    = r_cnt_clear;
  assign cnt_enable   = r_cnt_enable;
  assign busy         = r_busy;
  assign result       = r_result;
  assign result_ovf   = r_result_ovf;
  assign result_valid = r_result_valid;

endmodule

// File: tb/tb_bcd_gate_ctrl.sv
// tb/tb_bcd_gate_ctrl.sv - scoreboard bench for bcd_gate_ctrl with G=10, S=2, H=3
module tb_bcd_gate_ctrl;

  localparam int unsigned G = 10;
  localparam int unsigned S = 2;
  localparam int unsigned H = 3;

  typedef struct packed {
    logic [15:0] res;
    logic        ovf;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        run;
  logic [15:0] count_in;
  logic        ovf_in;
  logic        cnt_clear;
  logic        cnt_enable;
  logic [15:0] result;
  logic        result_ovf;
  logic        result_valid;
  logic        busy;

  int   n_checks;
  int   n_fail;
  int   clr_seen;
  int   valid_seen;
  exp_t sb[$];

  bcd_gate_ctrl #(
    .GATE_CYCLES   (G),
    .SETTLE_CYCLES (S),
    .HOLD_CYCLES   (H)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .run          (run),
    .count_in     (count_in),
    .ovf_in       (ovf_in),
    .cnt_clear    (cnt_clear),
    .cnt_enable   (cnt_enable),
    .result       (result),
    .result_ovf   (result_ovf),
    .result_valid (result_valid),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (cnt_clear) clr_seen++;
      if (result_valid) begin
        valid_seen++;
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_valid: got result=%h ovf=%b, required no pulse", result, result_ovf);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if ({result, result_ovf} !== e) begin
            n_fail++;
            $display("FAIL sb_result: got %h/%b, required %h/%b", result, result_ovf, e.res, e.ovf);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; run = 1'b0; count_in = 16'h0; ovf_in = 1'b0;
    tick(3);
    n_checks++;
    if ({cnt_clear, cnt_enable, result, result_ovf, result_valid, busy} !== 21'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got clr=%b en=%b res=%h ovf=%b vld=%b busy=%b, required all 0",
               cnt_clear, cnt_enable, result, result_ovf, result_valid, busy);
    end
    rst_n = 1'b1;
    clr_seen = 0;
    tick(20);
    n_checks++;
    if (busy !== 1'b0 || clr_seen != 0) begin
      n_fail++;
      $display("FAIL idle_stays: got busy=%b clears=%0d, required 0/0", busy, clr_seen);
    end
  endtask

  task automatic test_single_window;
    count_in = 16'h1234;
    sb.push_back('{res: 16'h1234, ovf: 1'b0});
    run = 1'b1;
    tick(1);
    n_checks++;
    if (cnt_clear !== 1'b1 || cnt_enable !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL clear_pulse_e0: got clr=%b en=%b busy=%b, required 1/0/1", cnt_clear, cnt_enable, busy);
    end
    for (int k = 1; k <= int'(G); k++) begin
      tick(1);
      n_checks++;
      if (cnt_enable !== 1'b1 || cnt_clear !== 1'b0) begin
        n_fail++;
        $display("FAIL gate_on_e%0d: got en=%b clr=%b, required 1/0", k, cnt_enable, cnt_clear);
      end
    end
    tick(1);
    n_checks++;
    if (cnt_enable !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL gate_off_e11: got en=%b busy=%b, required 0/1", cnt_enable, busy);
    end
    tick(2);
    n_checks++;
    if (result_valid !== 1'b1 || result !== 16'h1234) begin
      n_fail++;
      $display("FAIL latch_e13: got vld=%b res=%h, required 1/1234", result_valid, result);
    end
    tick(1);
    n_checks++;
    if (result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_single_e14: got %b, required 0", result_valid);
    end
    tick(1);
    n_checks++;
    if (cnt_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL no_clear_e15: got %b, required 0", cnt_clear);
    end
    tick(1);
    n_checks++;
    if (cnt_clear !== 1'b1) begin
      n_fail++;
      $display("FAIL next_clear_e16: got %b, required 1", cnt_clear);
    end
    run = 1'b0;
    tick(1);
    n_checks++;
    if (busy !== 1'b0 || cnt_clear !== 1'b0 || result !== 16'h1234) begin
      n_fail++;
      $display("FAIL abort_clear: got busy=%b clr=%b res=%h, required 0/0/1234", busy, cnt_clear, result);
    end
  endtask

  task automatic test_abort_gate;
    int v0;
    count_in = 16'h5555;
    v0 = valid_seen;
    run = 1'b1;
    tick(6);
    n_checks++;
    if (cnt_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL abort_pre_gate: got en=%b, required 1", cnt_enable);
    end
    run = 1'b0;
    tick(1);
    n_checks++;
    if (busy !== 1'b0 || cnt_enable !== 1'b0 || result !== 16'h1234 || result_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_gate: got busy=%b en=%b res=%h vld=%b, required 0/0/1234/0",
               busy, cnt_enable, result, result_valid);
    end
    tick(20);
    n_checks++;
    if (valid_seen != v0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_no_valid: got pulses=%0d busy=%b, required 0/0", valid_seen - v0, busy);
    end
  endtask

  task automatic test_overflow_and_hold_stop;
    count_in = 16'h0007;
    sb.push_back('{res: 16'h0007, ovf: 1'b1});
    sb.push_back('{res: 16'h0007, ovf: 1'b0});
    run = 1'b1;
    tick(4);
    ovf_in = 1'b1;
    tick(1);
    ovf_in = 1'b0;
    tick(9);
    n_checks++;
    if (result_valid !== 1'b1 || result_ovf !== 1'b1 || result !== 16'h0007) begin
      n_fail++;
      $display("FAIL ovf_window: got vld=%b ovf=%b res=%h, required 1/1/0007", result_valid, result_ovf, result);
    end
    tick(16);
    n_checks++;
    if (result_valid !== 1'b1 || result_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_cleared: got vld=%b ovf=%b, required 1/0", result_valid, result_ovf);
    end
    run = 1'b0;
    clr_seen = 0;
    tick(2);
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_continues: got busy=%b, required 1", busy);
    end
    tick(1);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_to_idle: got busy=%b, required 0", busy);
    end
    tick(10);
    n_checks++;
    if (clr_seen != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL hold_stop_no_clear: got clears=%0d busy=%b, required 0/0", clr_seen, busy);
    end
  endtask

  task automatic test_reset_mid_gate;
    count_in = 16'h4321;
    run = 1'b1;
    tick(4);
    n_checks++;
    if (cnt_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_pre_gate: got en=%b, required 1", cnt_enable);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (cnt_enable !== 1'b0 || busy !== 1'b0 || result !== 16'h0 || result_ovf !== 1'b0 || cnt_clear !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: got en=%b busy=%b res=%h ovf=%b clr=%b, required 0/0/0000/0/0",
               cnt_enable, busy, result, result_ovf, cnt_clear);
    end
    tick(1);
    rst_n = 1'b1;
    tick(1);
    n_checks++;
    if (cnt_clear !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_restart: got clr=%b busy=%b, required 1/1", cnt_clear, busy);
    end
    run = 1'b0;
    tick(1);
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_restart_abort: got busy=%b, required 0", busy);
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; clr_seen = 0; valid_seen = 0;
    test_reset();
    test_single_window();
    test_abort_gate();
    test_overflow_and_hold_stop();
    test_reset_mid_gate();
    tick(5);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain: got %0d pending results, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
